// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with a fixed bit-clock prescaler, a metastability synchronizer,
// and a valid/ready byte output that flags framing errors and overruns.
module uart_rx_os #(
   parameter int unsigned PRESCALER   = 104,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_error,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CntW = $clog2(PRESCALER);
   localparam logic [CntW-1:0] CntFull = CntW'(PRESCALER - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(PRESCALER / 2 - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              fe_q, fe_d;
   logic              ov_q, ov_d;
   logic              done;
   logic [SYNC_STAGES-1:0] sync_q;
   logic              rx_s;

   // Synchronizer resets to all ones so the line looks idle coming out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         count_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
      done    = 1'b0;

      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (!rx_s) begin
               count_d = CntHalf;
               state_d = StStart;
            end
         end
         StStart: begin
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else if (rx_s) begin
               state_d = StIdle;
            end else begin
               count_d = CntFull;
               bit_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               shift_d = {rx_s, shift_q[7:1]};
               count_d = CntFull;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            // Leaving at mid-stop-bit keeps a back-to-back start edge from being missed.
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else if (rx_s) begin
               done    = 1'b1;
               state_d = StIdle;
            end else begin
               fe_d    = 1'b1;
               state_d = StBreak;
            end
         end
         StBreak: begin
            if (rx_s) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (done) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ov_d = 1'b1;
         end
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign frame_error = fe_q;
   assign overrun     = ov_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: table-driven byte stream at +/-3% baud plus
// hand-written sequences for glitch, framing error, overrun and mid-byte reset.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int unsigned ClkNs  = 10;
   localparam int unsigned BitNs  = 104 * ClkNs;
   localparam int unsigned FastNs = 1009;
   localparam int unsigned SlowNs = 1071;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] got[$];
   int fe_cnt = 0;
   int ov_cnt = 0;
   int both_cnt = 0;
   int valid_cycles = 0;
   logic busy_seen = 1'b0;

   typedef struct {
      logic [7:0]  data;
      int unsigned period_ns;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t       vecs[32];
   logic [7:0] pat[16];

   uart_rx_os #(
      .PRESCALER(104),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rx(rx),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .frame_error(frame_error),
      .overrun(overrun),
      .busy(busy)
   );

   always #(ClkNs / 2) clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid) valid_cycles++;
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_error && overrun) both_cnt++;
      if (busy) busy_seen = 1'b1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input int unsigned per, input logic stop);
      rx = 1'b0;
      #(per);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(per);
      end
      rx = stop;
      #(per);
      rx = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int base, fe0, ov0, vc0;

      pat = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'hC3,
              8'h3C, 8'h96, 8'h69, 8'hF0, 8'h0F, 8'h12, 8'hED, 8'hB7};
      for (int i = 0; i < 32; i++) begin
         vecs[i].data      = pat[i % 16];
         vecs[i].period_ns = (i < 16) ? SlowNs : FastNs;
         vecs[i].exp_data  = pat[i % 16];
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_data", {24'd0, rx_data}, 32'h00);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_frame_error", {31'd0, frame_error}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);

      // 1: single byte 0xA5
      base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cycles;
      send_byte(8'hA5, BitNs, 1'b1);
      #(2 * BitNs);
      check("t1_count", got.size() - base, 32'd1);
      if (got.size() > base) check("t1_data", {24'd0, got[base]}, 32'hA5);
      check("t1_valid_cycles", valid_cycles - vc0, 32'd1);
      check("t1_fe", fe_cnt - fe0, 32'd0);
      check("t1_ov", ov_cnt - ov0, 32'd0);

      // 2: 20-clock low glitch is a false start
      base = got.size(); fe0 = fe_cnt;
      @(posedge clk);
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (20) @(posedge clk);
      rx = 1'b1;
      wait_idle("t2_busy_clears", 84);
      check("t2_busy_seen", {31'd0, busy_seen}, 32'd1);
      #(BitNs);
      check("t2_no_byte", got.size() - base, 32'd0);
      check("t2_fe", fe_cnt - fe0, 32'd0);

      // 3: framing error then line held low, then a clean byte
      base = got.size(); fe0 = fe_cnt;
      send_byte(8'h3C, BitNs, 1'b0);
      rx = 1'b0;
      #(3 * BitNs);
      rx = 1'b1;
      #(BitNs);
      check("t3_fe_pulse", fe_cnt - fe0, 32'd1);
      check("t3_no_byte", got.size() - base, 32'd0);
      send_byte(8'h5A, BitNs, 1'b1);
      #(2 * BitNs);
      check("t3_count", got.size() - base, 32'd1);
      if (got.size() > base) check("t3_data", {24'd0, got[base]}, 32'h5A);

      // 4: overrun with consumer stalled
      rx_ready = 1'b0;
      base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      send_byte(8'h11, BitNs, 1'b1);
      send_byte(8'h22, BitNs, 1'b1);
      #(2 * BitNs);
      check("t4_valid_held", {31'd0, rx_valid}, 32'd1);
      check("t4_data_held", {24'd0, rx_data}, 32'h11);
      check("t4_ov_pulse", ov_cnt - ov0, 32'd1);
      check("t4_fe", fe_cnt - fe0, 32'd0);
      @(posedge clk);
      #2 rx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_valid_falls", {31'd0, rx_valid}, 32'd0);
      check("t4_consumed", got.size() - base, 32'd1);
      if (got.size() > base) check("t4_consumed_data", {24'd0, got[base]}, 32'h11);

      // 5: back-to-back bytes at +3% then -3% bit period
      base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      for (int i = 0; i < 32; i++) send_byte(vecs[i].data, vecs[i].period_ns, 1'b1);
      #(2 * BitNs);
      check("t5_count", got.size() - base, 32'd32);
      for (int i = 0; i < 32; i++) begin
         if (base + i < got.size())
            check($sformatf("t5_data_%0d", i), {24'd0, got[base+i]}, {24'd0, vecs[i].exp_data});
      end
      check("t5_fe", fe_cnt - fe0, 32'd0);
      check("t5_ov", ov_cnt - ov0, 32'd0);

      // 6: reset in the middle of data bit 4 of 0xFF
      rx = 1'b0;
      #(BitNs);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         #(BitNs);
      end
      #(BitNs / 2);
      check("t6_busy_before", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("t6_rx_data", {24'd0, rx_data}, 32'h00);
      check("t6_frame_error", {31'd0, frame_error}, 32'd0);
      check("t6_overrun", {31'd0, overrun}, 32'd0);
      #(6 * BitNs);
      @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      base = got.size();
      send_byte(8'h81, BitNs, 1'b1);
      #(2 * BitNs);
      check("t6_count", got.size() - base, 32'd1);
      if (got.size() > base) check("t6_data", {24'd0, got[base]}, 32'h81);

      check("never_both_flags", both_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
